// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX-stage operand forwarding and immediate select.
// Latency: one cycle from decode inputs to E registers; operand muxing is combinational.
// Backpressure: stall holds every E register, flush (or an invalid decode slot) loads a bubble.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      valid_d,
    input  logic [DATA_WIDTH-1:0]     pc_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic [DATA_WIDTH-1:0]     rd1_d,
    input  logic [DATA_WIDTH-1:0]     rd2_d,
    input  logic [DATA_WIDTH-1:0]     imm_ext_d,
    input  logic [2:0]                alu_ctrl_d,
    input  logic                      alu_src_d,
    input  logic                      reg_write_d,
    input  logic                      mem_write_d,
    input  logic                      branch_d,
    input  logic                      jump_d,
    input  logic [1:0]                result_src_d,
    input  logic [DATA_WIDTH-1:0]     alu_result_m,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m,
    input  logic                      reg_write_m,
    input  logic [DATA_WIDTH-1:0]     result_w,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w,
    input  logic                      reg_write_w,
    output logic [2:0]                ALUControl,
    output logic [DATA_WIDTH-1:0]     ALUop1,
    output logic [DATA_WIDTH-1:0]     ALUop2,
    output logic [DATA_WIDTH-1:0]     write_data_e,
    output logic [DATA_WIDTH-1:0]     pc_e,
    output logic [DATA_WIDTH-1:0]     imm_ext_e,
    output logic [REG_ADDR_WIDTH-1:0] rs1_e,
    output logic [REG_ADDR_WIDTH-1:0] rs2_e,
    output logic [REG_ADDR_WIDTH-1:0] rd_e,
    output logic                      reg_write_e,
    output logic                      mem_write_e,
    output logic                      branch_e,
    output logic                      jump_e,
    output logic                      valid_e,
    output logic [1:0]                result_src_e,
    output logic [1:0]                fwd_a_e,
    output logic [1:0]                fwd_b_e
);

    // All E-stage state in one packed record so a bubble is simply all-zero.
    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     pc;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]     rd1;
        logic [DATA_WIDTH-1:0]     rd2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [2:0]                alu_ctrl;
        logic                      alu_src;
        logic                      reg_write;
        logic                      mem_write;
        logic                      branch;
        logic                      jump;
        logic [1:0]                result_src;
    } ex_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    ex_t ex_q;
    ex_t ex_d;
    ex_t cap;

    // Pack the decode-stage fields into the E-stage record layout.
    always_comb begin
        cap            = '0;
        cap.valid      = valid_d;
        cap.pc         = pc_d;
        cap.rs1        = rs1_d;
        cap.rs2        = rs2_d;
        cap.rd         = rd_d;
        cap.rd1        = rd1_d;
        cap.rd2        = rd2_d;
        cap.imm        = imm_ext_d;
        cap.alu_ctrl   = alu_ctrl_d;
        cap.alu_src    = alu_src_d;
        cap.reg_write  = reg_write_d;
        cap.mem_write  = mem_write_d;
        cap.branch     = branch_d;
        cap.jump       = jump_d;
        cap.result_src = result_src_d;
    end

    // Next state: flush beats stall; an empty decode slot is captured as a bubble.
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d = valid_d ? cap : '0;
        end
    end

    // E-stage register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    // Forward select for one source index; MEM wins over WB, x0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs,
                                           input logic [REG_ADDR_WIDTH-1:0] rdm,
                                           input logic                      rwm,
                                           input logic [REG_ADDR_WIDTH-1:0] rdw,
                                           input logic                      rww);
        logic [1:0] sel;
        sel = FWD_RF;
        if (rwm && (rdm != '0) && (rdm == rs)) begin
            sel = FWD_MEM;
        end else if (rww && (rdw != '0) && (rdw == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Operand muxing from live M/W producers, so operands track them during a stall.
    always_comb begin
        fwd_a_e = fwd_sel(ex_q.rs1, rd_m, reg_write_m, rd_w, reg_write_w);
        fwd_b_e = fwd_sel(ex_q.rs2, rd_m, reg_write_m, rd_w, reg_write_w);

        case (fwd_a_e)
            FWD_MEM: ALUop1 = alu_result_m;
            FWD_WB:  ALUop1 = result_w;
            default: ALUop1 = ex_q.rd1;
        endcase

        case (fwd_b_e)
            FWD_MEM: write_data_e = alu_result_m;
            FWD_WB:  write_data_e = result_w;
            default: write_data_e = ex_q.rd2;
        endcase

        ALUop2 = ex_q.alu_src ? ex_q.imm : write_data_e;
    end

    assign ALUControl   = ex_q.alu_ctrl;
    assign pc_e         = ex_q.pc;
    assign imm_ext_e    = ex_q.imm;
    assign rs1_e        = ex_q.rs1;
    assign rs2_e        = ex_q.rs2;
    assign rd_e         = ex_q.rd;
    assign reg_write_e  = ex_q.reg_write;
    assign mem_write_e  = ex_q.mem_write;
    assign branch_e     = ex_q.branch;
    assign jump_e       = ex_q.jump;
    assign valid_e      = ex_q.valid;
    assign result_src_e = ex_q.result_src;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table plus stall/flush/reset sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
// No backpressure on the bench side; every wait is a bounded clock edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, valid_d;
    logic [31:0] pc_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [31:0] rd1_d, rd2_d, imm_ext_d;
    logic [2:0]  alu_ctrl_d;
    logic        alu_src_d, reg_write_d, mem_write_d, branch_d, jump_d;
    logic [1:0]  result_src_d;
    logic [31:0] alu_result_m;
    logic [4:0]  rd_m;
    logic        reg_write_m;
    logic [31:0] result_w;
    logic [4:0]  rd_w;
    logic        reg_write_w;

    logic [2:0]  ALUControl;
    logic [31:0] ALUop1, ALUop2, write_data_e, pc_e, imm_ext_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, valid_e;
    logic [1:0]  result_src_e, fwd_a_e, fwd_b_e;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_d(valid_d),
        .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d),
        .alu_ctrl_d(alu_ctrl_d), .alu_src_d(alu_src_d),
        .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
        .branch_d(branch_d), .jump_d(jump_d), .result_src_d(result_src_d),
        .alu_result_m(alu_result_m), .rd_m(rd_m), .reg_write_m(reg_write_m),
        .result_w(result_w), .rd_w(rd_w), .reg_write_w(reg_write_w),
        .ALUControl(ALUControl), .ALUop1(ALUop1), .ALUop2(ALUop2),
        .write_data_e(write_data_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .branch_e(branch_e), .jump_e(jump_e), .valid_e(valid_e),
        .result_src_e(result_src_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
    );

    typedef struct {
        logic        stall, flush, valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        logic [2:0]  ctrl;
        logic        src, rw, mw;
        logic [4:0]  rdm;
        logic        rwm;
        logic [31:0] resm;
        logic [4:0]  rdw;
        logic        rww;
        logic [31:0] resw;
        // expected after the edge
        logic [2:0]  x_ctrl;
        logic [31:0] x_op1, x_op2, x_wd, x_pc;
        logic [1:0]  x_fa, x_fb;
        logic        x_valid, x_rw, x_mw;
        logic [4:0]  x_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_d(input logic v, input logic [31:0] pc, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic [2:0] ctl,
                         input logic src, input logic rw, input logic mw);
        valid_d = v; pc_d = pc; rs1_d = s1; rs2_d = s2; rd_d = d;
        rd1_d = r1; rd2_d = r2; imm_ext_d = imm; alu_ctrl_d = ctl;
        alu_src_d = src; reg_write_d = rw; mem_write_d = mw;
        branch_d = 1'b0; jump_d = 1'b0; result_src_d = 2'b00;
    endtask

    task automatic set_mw(input logic [4:0] dm, input logic wm, input logic [31:0] rm,
                          input logic [4:0] dw, input logic ww, input logic [31:0] rw);
        rd_m = dm; reg_write_m = wm; alu_result_m = rm;
        rd_w = dw; reg_write_w = ww; result_w = rw;
    endtask

    function automatic vec_t blank(input int i);
        vec_t v;
        v = '{default: '0};
        v.valid = 1'b1;
        v.pc    = 32'h100 + 32'(4 * i);
        v.x_pc  = v.pc;
        v.x_valid = 1'b1;
        return v;
    endfunction

    initial begin
        vec_t v;

        // 0: reset release then first capture: SUB 7, 3
        v = blank(0); v.rs1 = 1; v.rs2 = 2; v.rd = 3; v.rd1 = 7; v.rd2 = 3; v.ctrl = 3'b001; v.rw = 1;
        v.x_ctrl = 3'b001; v.x_op1 = 7; v.x_op2 = 3; v.x_wd = 3; v.x_rw = 1; v.x_rd = 3;
        vecs.push_back(v);
        // 1: immediate select
        v = blank(1); v.rs1 = 1; v.rs2 = 2; v.rd = 4; v.rd1 = 10; v.rd2 = 5; v.imm = 32'hFFFF_FFFC; v.src = 1; v.rw = 1;
        v.x_op1 = 10; v.x_op2 = 32'hFFFF_FFFC; v.x_wd = 5; v.x_rw = 1; v.x_rd = 4;
        vecs.push_back(v);
        // 2: both M and W match rs1 -> MEM wins
        v = blank(2); v.rs1 = 4; v.rs2 = 6; v.rd = 8; v.rd1 = 32'h99; v.rd2 = 32'h55; v.ctrl = 3'b011; v.rw = 1;
        v.rdm = 4; v.rwm = 1; v.resm = 32'h11; v.rdw = 4; v.rww = 1; v.resw = 32'h22;
        v.x_ctrl = 3'b011; v.x_op1 = 32'h11; v.x_fa = 2'b10; v.x_op2 = 32'h55; v.x_wd = 32'h55; v.x_rw = 1; v.x_rd = 8;
        vecs.push_back(v);
        // 3: MEM write-enable dropped -> WB forward
        v = vecs[2]; v.pc = 32'h10C; v.x_pc = 32'h10C; v.rwm = 0;
        v.x_op1 = 32'h22; v.x_fa = 2'b01;
        vecs.push_back(v);
        // 4: rs1 from WB, rs2 from MEM
        v = blank(4); v.rs1 = 7; v.rs2 = 8; v.rd = 9; v.rd1 = 1; v.rd2 = 2; v.ctrl = 3'b010; v.mw = 1;
        v.rdm = 8; v.rwm = 1; v.resm = 32'h33; v.rdw = 7; v.rww = 1; v.resw = 32'h44;
        v.x_ctrl = 3'b010; v.x_op1 = 32'h44; v.x_fa = 2'b01; v.x_op2 = 32'h33; v.x_wd = 32'h33; v.x_fb = 2'b10;
        v.x_mw = 1; v.x_rd = 9;
        vecs.push_back(v);
        // 5: x0 never forwarded
        v = blank(5); v.rd1 = 5; v.rd2 = 6; v.rd = 1; v.rw = 1;
        v.rdm = 0; v.rwm = 1; v.resm = 32'hAA; v.rdw = 0; v.rww = 1; v.resw = 32'hBB;
        v.x_op1 = 5; v.x_op2 = 6; v.x_wd = 6; v.x_rw = 1; v.x_rd = 1;
        vecs.push_back(v);
        // 6: store: imm on ALUop2, forwarded rs2 as store data
        v = blank(6); v.rs1 = 9; v.rs2 = 10; v.rd1 = 32'h1000; v.rd2 = 32'hDEAD; v.imm = 32'h10; v.src = 1; v.mw = 1;
        v.rdm = 10; v.rwm = 1; v.resm = 32'h77;
        v.x_op1 = 32'h1000; v.x_op2 = 32'h10; v.x_wd = 32'h77; v.x_fb = 2'b10; v.x_mw = 1;
        vecs.push_back(v);
        // 7: empty decode slot -> bubble
        v = blank(7); v.valid = 0; v.rs1 = 3; v.rs2 = 3; v.rd = 5; v.rd1 = 32'h123; v.rd2 = 32'h456; v.ctrl = 3'b001; v.rw = 1; v.mw = 1;
        v.rdm = 3; v.rwm = 1; v.resm = 32'h5;
        v.x_pc = 0; v.x_valid = 0;
        vecs.push_back(v);
        // 8: flush with a valid instruction -> bubble
        v = blank(8); v.flush = 1; v.rs1 = 3; v.rd = 5; v.rd1 = 32'h321; v.ctrl = 3'b011; v.rw = 1; v.mw = 1;
        v.rdm = 3; v.rwm = 1; v.resm = 32'h5;
        v.x_pc = 0; v.x_valid = 0;
        vecs.push_back(v);
        // 9: SLT code passes through
        v = blank(9); v.rs1 = 11; v.rs2 = 12; v.rd = 13; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.ctrl = 3'b101; v.rw = 1;
        v.rdm = 3; v.rwm = 1; v.resm = 32'h5;
        v.x_ctrl = 3'b101; v.x_op1 = 32'hFFFF_FFFF; v.x_op2 = 1; v.x_wd = 1; v.x_rw = 1; v.x_rd = 13;
        vecs.push_back(v);

        // Reset: outputs zero even with a valid instruction and M/W activity driven.
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_d(1'b1, 32'h40, 5'd1, 5'd2, 5'd3, 32'h7, 32'h3, 32'h9, 3'b001, 1'b0, 1'b1, 1'b1);
        set_mw(5'd3, 1'b1, 32'h11, 5'd4, 1'b1, 32'h22);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl",  32'(ALUControl), 32'h0);
        chk("rst_op1",   ALUop1, 32'h0);
        chk("rst_op2",   ALUop2, 32'h0);
        chk("rst_wd",    write_data_e, 32'h0);
        chk("rst_valid", 32'(valid_e), 32'h0);
        chk("rst_fwd",   32'({fwd_a_e, fwd_b_e}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (i != 0) @(negedge clk);
            stall = v.stall; flush = v.flush;
            set_d(v.valid, v.pc, v.rs1, v.rs2, v.rd, v.rd1, v.rd2, v.imm, v.ctrl, v.src, v.rw, v.mw);
            set_mw(v.rdm, v.rwm, v.resm, v.rdw, v.rww, v.resw);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ctrl", i),  32'(ALUControl), 32'(v.x_ctrl));
            chk($sformatf("v%0d_op1", i),   ALUop1, v.x_op1);
            chk($sformatf("v%0d_op2", i),   ALUop2, v.x_op2);
            chk($sformatf("v%0d_wd", i),    write_data_e, v.x_wd);
            chk($sformatf("v%0d_fa", i),    32'(fwd_a_e), 32'(v.x_fa));
            chk($sformatf("v%0d_fb", i),    32'(fwd_b_e), 32'(v.x_fb));
            chk($sformatf("v%0d_valid", i), 32'(valid_e), 32'(v.x_valid));
            chk($sformatf("v%0d_rw", i),    32'(reg_write_e), 32'(v.x_rw));
            chk($sformatf("v%0d_mw", i),    32'(mem_write_e), 32'(v.x_mw));
            chk($sformatf("v%0d_rd", i),    32'(rd_e), 32'(v.x_rd));
            chk($sformatf("v%0d_pc", i),    pc_e, v.x_pc);
        end

        // Stall: load one instruction, then hold for 3 edges while D changes.
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        set_d(1'b1, 32'h200, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h0, 3'b001, 1'b0, 1'b1, 1'b0);
        set_mw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("stl_load_op1", ALUop1, 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            stall = 1'b1;
            set_d(1'b1, 32'h300 + 32'(k), 5'd1, 5'd1, 5'd1, 32'hDEAD, 32'hBEEF, 32'h5, 3'b010, 1'b1, 1'b0, 1'b1);
            @(posedge clk); #1;
            chk($sformatf("stl%0d_pc", k),   pc_e, 32'h200);
            chk($sformatf("stl%0d_ctrl", k), 32'(ALUControl), 32'h1);
            chk($sformatf("stl%0d_op1", k),  ALUop1, 32'h1);
            chk($sformatf("stl%0d_op2", k),  ALUop2, 32'h2);
            chk($sformatf("stl%0d_rd", k),   32'(rd_e), 32'h7);
            chk($sformatf("stl%0d_rw", k),   32'(reg_write_e), 32'h1);
            chk($sformatf("stl%0d_mw", k),   32'(mem_write_e), 32'h0);
        end
        // Live forwarding while held.
        @(negedge clk);
        set_mw(5'd5, 1'b1, 32'h55, 5'd0, 1'b0, 32'h0);
        #1;
        chk("stl_live_op1a", ALUop1, 32'h55);
        chk("stl_live_fa",   32'(fwd_a_e), 32'h2);
        alu_result_m = 32'h66;
        #1;
        chk("stl_live_op1b", ALUop1, 32'h66);

        // Flush beats stall on the same edge.
        flush = 1'b1;
        @(posedge clk); #1;
        chk("fl_valid", 32'(valid_e), 32'h0);
        chk("fl_rw",    32'(reg_write_e), 32'h0);
        chk("fl_mw",    32'(mem_write_e), 32'h0);
        chk("fl_ctrl",  32'(ALUControl), 32'h0);
        chk("fl_op1",   ALUop1, 32'h0);

        // Asynchronous reset between edges.
        @(negedge clk);
        stall = 1'b0; flush = 1'b0;
        set_d(1'b1, 32'h400, 5'd2, 5'd3, 5'd4, 32'h9, 32'h8, 32'h0, 3'b001, 1'b0, 1'b1, 1'b1);
        set_mw(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clk); #1;
        chk("ar_pre_ctrl", 32'(ALUControl), 32'h1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(valid_e), 32'h0);
        chk("ar_ctrl",  32'(ALUControl), 32'h0);
        chk("ar_op1",   ALUop1, 32'h0);
        chk("ar_mw",    32'(mem_write_e), 32'h0);
        chk("ar_pc",    pc_e, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ar_recap_ctrl", 32'(ALUControl), 32'h1);
        chk("ar_recap_op1",  ALUop1, 32'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and execute-operand selection for the RV32I pipelined core.
- Captures decoded fields from the decode stage each clock, with stall (hold) and flush (bubble) control.
- Drives the ALU's ALUControl, ALUop1 and ALUop2 directly, after EX/MEM and MEM/WB operand forwarding and immediate selection.
- Also supplies store data and the control bits consumed by MEM/WB.

Parameters:
- DATA_WIDTH, 32: datapath width.
- REG_ADDR_WIDTH, 5: register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all E-stage registers.
- flush  in  1  load a bubble on the next edge.
- valid_d  in  1  decode slot holds a real instruction.
- pc_d  in  DATA_WIDTH  instruction PC.
- rs1_d, rs2_d, rd_d  in  REG_ADDR_WIDTH each  register indices.
- rd1_d, rd2_d  in  DATA_WIDTH each  register-file read data.
- imm_ext_d  in  DATA_WIDTH  sign-extended immediate.
- alu_ctrl_d  in  3  ALU operation code.
- alu_src_d  in  1  1 = ALUop2 is immediate.
- reg_write_d, mem_write_d, branch_d, jump_d  in  1 each  control bits.
- result_src_d  in  2  write-back select.
- alu_result_m  in  DATA_WIDTH  MEM-stage ALU result.
- rd_m  in  REG_ADDR_WIDTH  MEM-stage destination.
- reg_write_m  in  1  MEM-stage write enable.
- result_w  in  DATA_WIDTH  WB-stage result.
- rd_w  in  REG_ADDR_WIDTH  WB-stage destination.
- reg_write_w  in  1  WB-stage write enable.
- ALUControl  out  3  to ALU.
- ALUop1, ALUop2  out  DATA_WIDTH each  to ALU.
- write_data_e  out  DATA_WIDTH  forwarded rs2 value, used as store data.
- pc_e, imm_ext_e  out  DATA_WIDTH each  registered copies.
- rs1_e, rs2_e, rd_e  out  REG_ADDR_WIDTH each  registered indices, for the hazard unit.
- reg_write_e, mem_write_e, branch_e, jump_e, valid_e  out  1 each  registered control, gated by bubble.
- result_src_e  out  2  registered.
- fwd_a_e, fwd_b_e  out  2 each  forward select: 00 = register file, 10 = MEM, 01 = WB.

Behaviour:
- Clock and reset: single clock, clk; rst is asynchronous, active-high. While rst = 1, every registered field is 0. Consequently ALUControl = 000, valid_e = 0, and ALUop1 = ALUop2 = write_data_e = 0 (no forward matches, because reg_write_m and reg_write_w are ignored when the index is 0).
- Register update, evaluated on each rising edge in priority order:
  - rst: as above.
  - flush = 1: load a bubble, regardless of stall.
  - stall = 1: all E registers hold.
  - Otherwise: capture every *_d input into the matching *_e register.
- Bubble contents: every field 0, including valid_e, reg_write_e, mem_write_e, branch_e and jump_e. The ALU therefore sees ADD 0 + 0, with no architectural effect.
- valid_d = 0 while not stalled or flushed: captured as a bubble (identical to flush).
- Latency: one cycle from D inputs to E registers. Forwarding and operand selection are combinational from E registers and M/W inputs, with zero added latency.
- Forward A (fwd_a_e):
  - 10 if reg_write_m, rd_m != 0 and rd_m == rs1_e;
  - else 01 if reg_write_w, rd_w != 0 and rd_w == rs1_e;
  - else 00.
  - MEM has priority over WB when both match.
- Forward B (fwd_b_e): identical logic, using rs2_e.
- Register x0: never forwarded; rd = 0 in M or W is ignored.
- Operand outputs:
  - ALUop1 = forwarded rs1 value.
  - write_data_e = forwarded rs2 value.
  - ALUop2 = imm_ext_e when the registered alu_src is 1, else write_data_e.
- ALUControl: the registered alu_ctrl, passed unchanged. Codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT. Other codes pass through; the ALU outputs 0 for them.
- Forwarding during stall: continues to update from live M/W inputs while the E registers hold. The operands therefore track new producers.
- Reset mid-stall or mid-flush: reset wins immediately (asynchronous). The first capture happens on the first edge after rst falls.
- No width extension or truncation: all data paths are DATA_WIDTH bits.

Test Plan:
- Reset/capture: rst = 1, then release; drive alu_ctrl_d = 001, rd1_d = 7, rd2_d = 3, alu_src_d = 0, valid_d = 1 → outputs are 0 during reset; one edge later ALUControl = 001, ALUop1 = 7, ALUop2 = 3, valid_e = 1.
- Immediate select: alu_src_d = 1, imm_ext_d = 0xFFFFFFFC, rd2_d = 5 → ALUop2 = 0xFFFFFFFC, write_data_e = 5.
- Forward priority and x0:
  - rs1_e = 4; rd_m = 4, reg_write_m = 1, alu_result_m = 0x11; rd_w = 4, reg_write_w = 1, result_w = 0x22 → ALUop1 = 0x11, fwd_a_e = 10.
  - Drop reg_write_m → ALUop1 = 0x22, fwd_a_e = 01.
  - rs1_e = rd_m = 0 → fwd_a_e = 00.
- Stall hold: stall = 1 for 3 cycles while D inputs change → all E registers unchanged. Changing alu_result_m with a matching rd_m updates ALUop1 live.
- Flush beats stall: stall = 1 and flush = 1 on the same edge → valid_e = 0, reg_write_e = 0, mem_write_e = 0, ALUControl = 000.
- Async reset mid-operation: assert rst between edges with a valid instruction in E → outputs go to 0 before the next edge.
